// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with registered read data and occupancy-derived status flags.
// Define FIFO_FLAGS_ERR_EN to compile in the sticky overflow/underflow error flags.
module fifo_flags #(
    parameter int BITNUMBER       = 8,
    parameter int LENGTH          = 8,
    parameter int ALMOST_FULL_TH  = LENGTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Fifo_wr,
    input  logic                       Fifo_rd,
    input  logic [BITNUMBER-1:0]       Fifo_Data_in,
    output logic [BITNUMBER-1:0]       Fifo_Data_out,
    output logic                       Fifo_valid,
    output logic [$clog2(LENGTH):0]    Fifo_count,
    output logic                       Fifo_full,
    output logic                       Fifo_empty,
    output logic                       Fifo_almost_full,
    output logic                       Fifo_almost_empty,
    output logic                       Fifo_overflow,
    output logic                       Fifo_underflow
);
    localparam int PW = $clog2(LENGTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(LENGTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_COUNT   = CW'(ALMOST_EMPTY_TH);

    logic [BITNUMBER-1:0] mem [LENGTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 rd_ok;
    logic                 wr_ok;

    assign rd_ok = Fifo_rd && (count != '0);
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign wr_ok = Fifo_wr && ((count != FULL_COUNT) || rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            Fifo_Data_out <= '0;
            Fifo_valid    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr        <= rd_ptr + PW'(1);
                Fifo_Data_out <= mem[rd_ptr];
            end
            Fifo_valid <= rd_ok;
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage is not cleared on reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= Fifo_Data_in;
        end
    end

    assign Fifo_count        = count;
    assign Fifo_full         = (count == FULL_COUNT);
    assign Fifo_empty        = (count == '0);
    assign Fifo_almost_full  = (count >= AF_COUNT);
    assign Fifo_almost_empty = (count <= AE_COUNT);

`ifdef FIFO_FLAGS_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            Fifo_overflow  <= 1'b0;
            Fifo_underflow <= 1'b0;
        end else begin
            if (Fifo_wr && !wr_ok) begin
                Fifo_overflow <= 1'b1;
            end
            if (Fifo_rd && !rd_ok) begin
                Fifo_underflow <= 1'b1;
            end
        end
    end
`else
    assign Fifo_overflow  = 1'b0;
    assign Fifo_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: directed and randomized checks of fifo_flags against a queue-based model.
// Expected error flags follow FIFO_FLAGS_ERR_EN in the same way as the design.
module tb_fifo_flags;
    localparam int LEN = 8;
    localparam int AFT = 6;
    localparam int AET = 2;
`ifdef FIFO_FLAGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       valid;
    logic [3:0] count;
    logic       full, empty, afull, aempty, ovf, unf;

    int  tests = 0;
    int  failures = 0;
    bit  checking = 1'b0;

    logic [7:0] q[$];
    logic [7:0] m_out = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    fifo_flags #(
        .BITNUMBER(8), .LENGTH(LEN), .ALMOST_FULL_TH(AFT), .ALMOST_EMPTY_TH(AET)
    ) dut (
        .clk(clk), .reset(reset), .Fifo_wr(wr), .Fifo_rd(rd), .Fifo_Data_in(din),
        .Fifo_Data_out(dout), .Fifo_valid(valid), .Fifo_count(count),
        .Fifo_full(full), .Fifo_empty(empty), .Fifo_almost_full(afull),
        .Fifo_almost_empty(aempty), .Fifo_overflow(ovf), .Fifo_underflow(unf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a plain queue of words, updated on every rising edge.
    always @(posedge clk) begin
        bit rd_acc, wr_acc;
        if (reset) begin
            q.delete();
            m_out = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            rd_acc = rd && (q.size() > 0);
            wr_acc = wr && ((q.size() < LEN) || rd_acc);
            if (rd_acc) m_out = q.pop_front();
            m_valid = rd_acc;
            if (wr_acc) q.push_back(din);
            if (ERR_EN && wr && !wr_acc) m_ovf = 1'b1;
            if (ERR_EN && rd && !rd_acc) m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("count", count, q.size());
            checkOutput("full", full, q.size() == LEN);
            checkOutput("empty", empty, q.size() == 0);
            checkOutput("almost_full", afull, q.size() >= AFT);
            checkOutput("almost_empty", aempty, q.size() <= AET);
            checkOutput("data_out", dout, m_out);
            checkOutput("valid", valid, m_valid);
            checkOutput("overflow", ovf, m_ovf);
            checkOutput("underflow", unf, m_unf);
        end
    end

    task automatic applyStimulus(input bit r, input bit w, input bit rq, input logic [7:0] d);
        reset = r; wr = w; rd = rq; din = d;
        @(posedge clk);
        #1;
        reset = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 1, 1, 8'hFF);
        checking = 1'b1;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_aempty", aempty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_dout", dout, 8'h00);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_errors", {ovf, unf}, 2'b00);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 8'h0A + 8'(i));
            if (i == 1) checkOutput("aempty_at2", aempty, 1);
            if (i == 2) checkOutput("aempty_at3", aempty, 0);
        end
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("first_read_dout", dout, 8'h0A);
        checkOutput("first_read_valid", valid, 1);
        checkOutput("first_read_count", count, 3);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("valid_one_cycle", valid, 0);
        checkOutput("dout_held", dout, 8'h0A);

        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 8'(i + 1));
            if (i == 4) checkOutput("afull_at5", afull, 0);
            if (i == 5) checkOutput("afull_at6", afull, 1);
            if (i == 6) checkOutput("full_at7", full, 0);
        end
        checkOutput("full_at8", full, 1);
        applyStimulus(0, 1, 0, 8'h09);
        checkOutput("overwrite_count", count, 8);
        checkOutput("overflow_flag", ovf, ERR_EN);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 8'h00);
            checkOutput("drain_data", dout, 8'(i + 1));
        end
        checkOutput("drained_empty", empty, 1);

        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'h20 + 8'(i));
        applyStimulus(0, 1, 1, 8'h55);
        checkOutput("full_rw_count", count, 8);
        checkOutput("full_rw_dout", dout, 8'h20);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 8'h00);
        checkOutput("full_rw_last", dout, 8'h55);
        applyStimulus(0, 1, 1, 8'h66);
        checkOutput("empty_rw_count", count, 1);
        checkOutput("empty_rw_valid", valid, 0);
        checkOutput("empty_rw_unf", unf, ERR_EN);

        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, 8'hA0 + 8'(i));
            applyStimulus(0, 0, 1, 8'h00);
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 8'h00);
            checkOutput("wrap_data", dout, 8'h10 + 8'(i));
        end

        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'h40 + 8'(i));
        applyStimulus(1, 1, 1, 8'h77);
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_empty", empty, 1);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("midrst_valid", valid, 0);
        checkOutput("midrst_dout", dout, 8'h00);
        checkOutput("midrst_unf", unf, ERR_EN);

        for (int i = 0; i < 2000; i++) begin
            int wbias;
            wbias = ((i / 100) % 2 == 0) ? 70 : 30;
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 99) < wbias),
                          ($urandom_range(0, 99) < (100 - wbias)),
                          8'($urandom));
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 Parameter BITNUMBER, default 8, data word width in bits.
REQ-002 Parameter LENGTH, default 8, depth in words; power of two, >= 4.
REQ-003 Parameter ALMOST_FULL_TH, default LENGTH-2, almost-full threshold in words.
REQ-004 Parameter ALMOST_EMPTY_TH, default 2, almost-empty threshold in words.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 Fifo_wr  input  1  write request.
REQ-008 Fifo_rd  input  1  read request.
REQ-009 Fifo_Data_in  input  BITNUMBER  write data.
REQ-010 Fifo_Data_out  output  BITNUMBER  registered read data.
REQ-011 Fifo_valid  output  1  Fifo_Data_out updated by an accepted read this cycle.
REQ-012 Fifo_count  output  $clog2(LENGTH)+1  current occupancy, 0..LENGTH.
REQ-013 Fifo_full, Fifo_empty, Fifo_almost_full, Fifo_almost_empty  output  1 each  status flags.
REQ-014 Fifo_overflow, Fifo_underflow  output  1 each  sticky error flags.

Function
REQ-015 Write accepted when Fifo_wr=1 and (count<LENGTH, or count=LENGTH with a read accepted in the same cycle); Fifo_Data_in stored at write pointer.
REQ-016 Read accepted when Fifo_rd=1 and count>0; no same-cycle write-to-read bypass when empty.
REQ-017 Accepted read: Fifo_Data_out loads the oldest word on that edge (1-cycle latency); Fifo_valid=1 for exactly that following cycle.
REQ-018 No accepted read: Fifo_Data_out holds its value; Fifo_valid=0.
REQ-019 Pointers are log2(LENGTH) bits and wrap modulo LENGTH; FIFO order preserved across wrap.
REQ-020 Count: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-021 Fifo_full = (count==LENGTH); Fifo_empty = (count==0).
REQ-022 Fifo_almost_full = (count>=ALMOST_FULL_TH); Fifo_almost_empty = (count<=ALMOST_EMPTY_TH).
REQ-023 All flags derived from registered count; they change on the same edge as count.
REQ-024 Rejected write (full, no read) leaves memory, pointers and count unchanged.
REQ-025 Rejected read (empty) leaves Fifo_Data_out, pointers and count unchanged.

Reset
REQ-026 reset has priority over Fifo_wr/Fifo_rd in the same cycle.
REQ-027 On reset edge: pointers=0, count=0, Fifo_Data_out=0, Fifo_valid=0, Fifo_overflow=0, Fifo_underflow=0; hence Fifo_empty=1, Fifo_almost_empty=1, Fifo_full=0, Fifo_almost_full=0.
REQ-028 Reset mid-operation discards all stored words; memory contents need not be cleared.

Configuration
REQ-029 Macro FIFO_FLAGS_ERR_EN compiles in the sticky error logic.
REQ-030 Defined: Fifo_overflow sets on a rejected write, Fifo_underflow sets on a rejected read; both stay set until reset.
REQ-031 Not defined: Fifo_overflow and Fifo_underflow remain ports, tied to 0; all other behaviour identical.

Verification (BITNUMBER=8, LENGTH=8, ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=2)
REQ-032 reset=1 two cycles -> count=0, empty=1, almost_empty=1, Data_out=0x00, valid=0, full=0, errors=0.
REQ-033 Write 0x0A,0x0B,0x0C,0x0D, then one read -> next cycle Data_out=0x0A, valid=1 for one cycle, count=3; almost_empty drops when count reaches 3.
REQ-034 From empty, write 0x01..0x08, then write 0x09 -> almost_full at count 6, full at 8; 0x09 dropped, count=8, overflow=1 (macro on) / 0 (off); eight reads return 0x01..0x08, empty=1 after last.
REQ-035 With count=8, Fifo_wr=Fifo_rd=1, Data_in=0x55 -> count stays 8, oldest word read out, 0x55 later read last; with count=0 same stimulus -> count=1, valid=0, underflow=1 (macro on).
REQ-036 Wrap: write/read 6 words, then write 0x10..0x17 and read 8 -> output 0x10..0x17 in order, no data loss.
REQ-037 Reset asserted with count=5 -> count=0, empty=1 on that edge; subsequent read -> valid=0, Data_out=0x00, underflow=1 (macro on).
